// File: rtl/mem_access.sv
// mem_access: memory-access stage downstream of the dual-issue execute stage.
// Runs the data-bus request/response handshake for the single load/store
// picked from the two execute lanes, stalls upstream while the access is in
// flight, flags misaligned addresses, aligns and extends load data, and emits
// a one-cycle completion pulse toward writeback.
//
// Ports
//   clk, reset          pipeline clock, asynchronous active-high reset
//   req_*               op from execute: valid, lane, op code, address, store data
//   flush               kill the in-flight op (no completion)
//   dreq_*              bus request: valid, address, size, byte strobes, store data
//   dresp_*             bus response: address accepted, data/ack, raw load word
//   m_wait              stall for upstream stages
//   done_*              completion pulse, lane, aligned/extended load result
//   adel, ades          load/store address error (with done_valid)
//   badvaddr            faulting address
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_lane,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        m_wait,
  output logic        done_valid,
  output logic        done_lane,
  output logic [31:0] done_data,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr
);

  localparam logic [2:0] OpLb  = 3'd0;
  localparam logic [2:0] OpLbu = 3'd1;
  localparam logic [2:0] OpLh  = 3'd2;
  localparam logic [2:0] OpLhu = 3'd3;
  localparam logic [2:0] OpLw  = 3'd4;
  localparam logic [2:0] OpSb  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSw  = 3'd7;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic        lane_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        kill_q;     // flushed while the request is still waiting for addr_ok
  logic        adel_q;
  logic        ades_q;
  logic [31:0] badvaddr_q;
  logic [31:0] done_data_q;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OpSb;
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    unique case (op)
      OpLb, OpLbu, OpSb: return 2'd0;
      OpLh, OpLhu, OpSh: return 2'd1;
      default:           return 2'd2;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    unique case (op_size(op))
      2'd1:    return off[0];
      2'd2:    return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Stores complete with a zero result; loads pick and extend their byte/half.
  function automatic logic [31:0] load_result(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? w[31:16] : w[15:0];
    unique case (op)
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'd0, b};
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'd0, h};
      OpLw:    return w;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      lane_q      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      kill_q      <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      badvaddr_q  <= 32'd0;
      done_data_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && !flush) begin
            op_q        <= req_op;
            lane_q      <= req_lane;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            kill_q      <= 1'b0;
            done_data_q <= 32'd0;
            if (misaligned(req_op, req_addr[1:0])) begin
              adel_q     <= !is_store(req_op);
              ades_q     <= is_store(req_op);
              badvaddr_q <= req_addr;
              state_q    <= StDone;
            end else begin
              adel_q     <= 1'b0;
              ades_q     <= 1'b0;
              badvaddr_q <= 32'd0;
              state_q    <= StReq;
            end
          end
        end
        StReq: begin
          // The request stays up until accepted even when killed.
          if (dresp_addr_ok) begin
            if (kill_q || flush) begin
              state_q <= dresp_data_ok ? StIdle : StDrain;
            end else if (dresp_data_ok) begin
              done_data_q <= load_result(op_q, addr_q[1:0], dresp_data);
              state_q     <= StDone;
            end else begin
              state_q <= StWait;
            end
            kill_q <= 1'b0;
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= dresp_data_ok ? StIdle : StDrain;
          end else if (dresp_data_ok) begin
            done_data_q <= load_result(op_q, addr_q[1:0], dresp_data);
            state_q     <= StDone;
          end
        end
        StDrain: begin
          if (dresp_data_ok) state_q <= StIdle;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    dreq_strobe = 4'b0000;
    dreq_data   = 32'd0;
    unique case (op_q)
      OpSb: begin
        dreq_strobe = 4'b0001 << addr_q[1:0];
        dreq_data   = {4{wdata_q[7:0]}};
      end
      OpSh: begin
        dreq_strobe = 4'b0011 << addr_q[1:0];
        dreq_data   = {2{wdata_q[15:0]}};
      end
      OpSw: begin
        dreq_strobe = 4'b1111;
        dreq_data   = wdata_q;
      end
      default: ;
    endcase
  end

  assign dreq_valid = (state_q == StReq);
  assign dreq_addr  = addr_q;
  assign dreq_size  = op_size(op_q);

  // Gated by reset so the stall drops together with every other output.
  assign m_wait = !reset && (((state_q == StIdle) && req_valid) || (state_q == StReq) ||
                             (state_q == StWait) || (state_q == StDrain));

  assign done_valid = (state_q == StDone) && !flush;
  assign done_lane  = done_valid && lane_q;
  assign done_data  = done_data_q;
  assign adel       = done_valid && adel_q;
  assign ades       = done_valid && ades_q;
  assign badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: inputs change on the falling edge, outputs are
// checked 1 ns later, so each check observes one full pipeline cycle.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_lane;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        m_wait;
  logic        done_valid;
  logic        done_lane;
  logic [31:0] done_data;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_lane     (req_lane),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .m_wait       (m_wait),
    .done_valid   (done_valid),
    .done_lane    (done_lane),
    .done_data    (done_data),
    .adel         (adel),
    .ades         (ades),
    .badvaddr     (badvaddr)
  );

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_lane = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'd0;
    @(negedge clk); #1;
    checks++;
    if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, m_wait, done_valid,
         done_lane, done_data, adel, ades, badvaddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%h m_wait=%b done=%b want all zero",
               dreq_valid, dreq_addr, m_wait, done_valid);
    end
    @(negedge clk); reset = 1'b0;
    #1;
    checks++;
    if (m_wait !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got m_wait=%b done=%b want 0 0", m_wait, done_valid);
    end
  endtask

  // Zero-wait load: accept t, REQ t+1 (addr_ok), WAIT t+2 (data_ok), done t+3.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [1:0] exp_size,
                         input logic [31:0] exp_data, input string name);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_lane = 1'b1; req_wdata = 32'h5555_5555;
    #1;
    checks++;
    if (m_wait !== 1'b1) begin
      errors++; $display("FAIL %s_wait_t: got %b want 1", name, m_wait);
    end
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b1;
    #1;
    checks++;
    if (dreq_valid !== 1'b1 || dreq_addr !== addr || dreq_size !== exp_size ||
        dreq_strobe !== 4'b0000 || m_wait !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: got v=%b a=%h sz=%0d st=%b w=%b want 1 %h %0d 0000 1",
               name, dreq_valid, dreq_addr, dreq_size, dreq_strobe, m_wait, addr, exp_size);
    end
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1; dresp_data = rdata;
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || m_wait !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait: got v=%b w=%b done=%b want 0 1 0",
               name, dreq_valid, m_wait, done_valid);
    end
    @(negedge clk);
    dresp_data_ok = 1'b0; dresp_data = 32'd0;
    #1;
    checks++;
    if (done_valid !== 1'b1 || done_data !== exp_data || done_lane !== 1'b1 ||
        m_wait !== 1'b0 || adel !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b data=%h lane=%b w=%b adel=%b want 1 %h 1 0 0",
               name, done_valid, done_data, done_lane, m_wait, adel, exp_data);
    end
    @(negedge clk); #1;
    checks++;
    if (done_valid !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse: got %b want 0", name, done_valid);
    end
  endtask

  task automatic test_load_extend;
    do_load(3'd4, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF, "lw");
    do_load(3'd0, 32'h0000_1003, 32'h80FF_FFFF, 2'd0, 32'hFFFF_FF80, "lb");
    do_load(3'd1, 32'h0000_1003, 32'h80FF_FFFF, 2'd0, 32'h0000_0080, "lbu");
    do_load(3'd3, 32'h0000_1002, 32'h8001_0000, 2'd1, 32'h0000_8001, "lhu");
    do_load(3'd2, 32'h0000_1002, 32'h8001_0000, 2'd1, 32'hFFFF_8001, "lh");
    do_load(3'd0, 32'h0000_1001, 32'h1234_7F00, 2'd0, 32'h0000_007F, "lb_pos");
  endtask

  task automatic test_store_stall;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h0000_2002; req_wdata = 32'h1234_ABCD;
    req_lane = 1'b0;
    #1;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'h0;
    // addr_ok held off for four REQ cycles, then given on the fifth
    for (int i = 0; i < 5; i++) begin
      dresp_addr_ok = (i == 4);
      #1;
      checks++;
      if (dreq_valid !== 1'b1 || dreq_addr !== 32'h0000_2002 || dreq_size !== 2'd1 ||
          dreq_strobe !== 4'b1100 || dreq_data !== 32'hABCD_ABCD || m_wait !== 1'b1) begin
        errors++;
        $display("FAIL sh_req_%0d: got v=%b a=%h sz=%0d st=%b d=%h w=%b want 1 2002 1 1100 abcdabcd 1",
                 i, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, m_wait);
      end
      @(negedge clk);
    end
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1;
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL sh_wait: got v=%b done=%b want 0 0", dreq_valid, done_valid);
    end
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    checks++;
    if (done_valid !== 1'b1 || done_data !== 32'd0 || ades !== 1'b0 || done_lane !== 1'b0) begin
      errors++;
      $display("FAIL sh_done: got done=%b data=%h ades=%b lane=%b want 1 0 0 0",
               done_valid, done_data, ades, done_lane);
    end
    // SB with addr_ok and data_ok together: done at t+2
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h0000_2101; req_wdata = 32'h1234_ABCD;
    #1;
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    #1;
    checks++;
    if (dreq_valid !== 1'b1 || dreq_size !== 2'd0 || dreq_strobe !== 4'b0010 ||
        dreq_data !== 32'hCDCD_CDCD) begin
      errors++;
      $display("FAIL sb_req: got v=%b sz=%0d st=%b d=%h want 1 0 0010 cdcdcdcd",
               dreq_valid, dreq_size, dreq_strobe, dreq_data);
    end
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    #1;
    checks++;
    if (done_valid !== 1'b1 || m_wait !== 1'b0) begin
      errors++; $display("FAIL sb_done: got done=%b w=%b want 1 0", done_valid, m_wait);
    end
  endtask

  task automatic test_misaligned;
    logic [2:0]  ops [3];
    logic [31:0] addrs [3];
    logic        exp_adel [3];
    ops[0] = 3'd4; addrs[0] = 32'h0000_1002; exp_adel[0] = 1'b1;
    ops[1] = 3'd6; addrs[1] = 32'h0000_1001; exp_adel[1] = 1'b0;
    ops[2] = 3'd2; addrs[2] = 32'h0000_3003; exp_adel[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = ops[i]; req_addr = addrs[i]; req_lane = 1'b1;
      #1;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (done_valid !== 1'b1 || adel !== exp_adel[i] || ades !== !exp_adel[i] ||
          badvaddr !== addrs[i] || dreq_valid !== 1'b0 || m_wait !== 1'b0) begin
        errors++;
        $display("FAIL misalign_%0d: got done=%b adel=%b ades=%b bad=%h v=%b w=%b want 1 %b %b %h 0 0",
                 i, done_valid, adel, ades, badvaddr, dreq_valid, m_wait,
                 exp_adel[i], !exp_adel[i], addrs[i]);
      end
      @(negedge clk); #1;
      checks++;
      if (done_valid !== 1'b0 || dreq_valid !== 1'b0) begin
        errors++;
        $display("FAIL misalign_after_%0d: got done=%b v=%b want 0 0", i, done_valid, dreq_valid);
      end
    end
  endtask

  task automatic test_flush_wait;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_3000; req_lane = 1'b0;
    #1;
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    dresp_addr_ok = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (done_valid !== 1'b0 || m_wait !== 1'b1) begin
      errors++; $display("FAIL flush_wait: got done=%b w=%b want 0 1", done_valid, m_wait);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (m_wait !== 1'b1 || dreq_valid !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain: got w=%b v=%b done=%b want 1 0 0", m_wait, dreq_valid, done_valid);
    end
    @(negedge clk);
    dresp_data_ok = 1'b1; dresp_data = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (m_wait !== 1'b1 || done_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drain_ok: got w=%b done=%b want 1 0", m_wait, done_valid);
    end
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    checks++;
    if (m_wait !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got w=%b done=%b want 0 0", m_wait, done_valid);
    end
    // next op goes straight through
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_3004; req_lane = 1'b1;
    #1;
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h55AA_1234;
    #1;
    checks++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 32'h0000_3004) begin
      errors++;
      $display("FAIL flush_next_req: got v=%b a=%h want 1 00003004", dreq_valid, dreq_addr);
    end
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    #1;
    checks++;
    if (done_valid !== 1'b1 || done_data !== 32'h55AA_1234 || done_lane !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_done: got done=%b data=%h lane=%b want 1 55aa1234 1",
               done_valid, done_data, done_lane);
    end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h0000_4008; req_wdata = 32'hCAFE_F00D;
    req_lane = 1'b1;
    #1;
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    #1;
    checks++;
    if (m_wait !== 1'b1 || dreq_strobe !== 4'b1111 || dreq_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL sw_wait: got w=%b st=%b d=%h want 1 1111 cafef00d",
               m_wait, dreq_strobe, dreq_data);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, m_wait, done_valid,
         done_lane, done_data, adel, ades, badvaddr} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: got a=%h st=%b d=%h w=%b want all zero",
               dreq_addr, dreq_strobe, dreq_data, m_wait);
    end
    @(negedge clk);
    reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 32'h1111_2222;
    #1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    checks++;
    if (done_valid !== 1'b0 || m_wait !== 1'b0 || dreq_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_data_ok: got done=%b w=%b v=%b want 0 0 0",
               done_valid, m_wait, dreq_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_extend();
    test_store_stall();
    test_misaligned();
    test_flush_wait();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
